// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if: request/response handshake between the processor port
// decode and the sequencer, plus the RTC strobe pins. The multiplexed data bus
// `salient` is bidirectional and stays a plain inout port on the sequencer.
interface rtc_bus_sequencer_if;
    logic       req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       AD;
    logic       CS;
    logic       WR;
    logic       RD;

    // Sequencer side: takes requests, drives status and RTC strobes.
    modport slave (
        input  req, rw, addr, wdata,
        output busy, done, rdata, AD, CS, WR, RD
    );

    // Requester side: issues requests and observes status and strobes.
    modport master (
        output req, rw, addr, wdata,
        input  busy, done, rdata, AD, CS, WR, RD
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: runs one single-byte read or write on the RTC multiplexed
// bus per request. Address phase (A_SET/A_STB/A_HLD) then data phase
// (D_SET/D_STB/D_HLD), each state T_PH cycles long. Bus outputs are decoded
// from the state register, so an asynchronous reset forces idle pin levels at
// once. Optional macro RTC_SEQ_RECOVERY_EN adds a RECOVER state of T_PH
// cycles with CS high after every transaction, during which busy stays high.
module rtc_bus_sequencer #(
    parameter int unsigned T_PH = 4
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_sequencer_if.slave bus,
    inout  wire  [7:0]         salient
);

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_STB,
        A_HLD,
        D_SET,
        D_STB,
        D_HLD
`ifdef RTC_SEQ_RECOVERY_EN
        , RECOVER
`endif
    } state_t;

    // Phase counter reload value: counts T_PH-1 down to 0 in every state.
    localparam logic [3:0] PH_LAST = 4'(T_PH - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] ph_cnt;
    logic       ph_last;
    logic       accept;

    logic       rw_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       done_q;

    logic       cs;
    logic       wr;
    logic       rd;
    logic       ad;
    logic       busy;
    logic       drv_en;
    logic [7:0] drv_data;

    assign ph_last = (ph_cnt == 4'd0);
    assign accept  = (state == IDLE) && bus.req;

    // State register and phase counter; the counter reloads on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ph_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                ph_cnt <= PH_LAST;
            end else if (ph_cnt != 4'd0) begin
                ph_cnt <= ph_cnt - 4'd1;
            end
        end
    end

    // Control registers: transfer direction, completion pulse and read-back byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q    <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            if (accept) begin
                rw_q <= bus.rw;
            end
            done_q <= (state == D_HLD) && ph_last;
            if ((state == D_STB) && ph_last && rw_q) begin
                rdata_q <= salient;
            end
        end
    end

    // Address and write data are captured on accept; they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Next-state and Moore decode of the bus pins from the current state.
    always_comb begin
        state_nxt = state;
        cs        = 1'b1;
        wr        = 1'b1;
        rd        = 1'b1;
        ad        = 1'b1;
        busy      = 1'b1;
        drv_en    = 1'b0;
        drv_data  = addr_q;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.req) begin
                    state_nxt = A_SET;
                end
            end
            A_SET: begin
                cs     = 1'b0;
                ad     = 1'b0;
                drv_en = 1'b1;
                if (ph_last) begin
                    state_nxt = A_STB;
                end
            end
            A_STB: begin
                cs     = 1'b0;
                ad     = 1'b0;
                wr     = 1'b0;
                drv_en = 1'b1;
                if (ph_last) begin
                    state_nxt = A_HLD;
                end
            end
            A_HLD: begin
                cs     = 1'b0;
                ad     = 1'b0;
                drv_en = 1'b1;
                if (ph_last) begin
                    state_nxt = D_SET;
                end
            end
            D_SET: begin
                cs       = 1'b0;
                drv_en   = !rw_q;
                drv_data = wdata_q;
                if (ph_last) begin
                    state_nxt = D_STB;
                end
            end
            D_STB: begin
                cs       = 1'b0;
                wr       = rw_q;
                rd       = !rw_q;
                drv_en   = !rw_q;
                drv_data = wdata_q;
                if (ph_last) begin
                    state_nxt = D_HLD;
                end
            end
            D_HLD: begin
                cs       = 1'b0;
                drv_en   = !rw_q;
                drv_data = wdata_q;
                if (ph_last) begin
`ifdef RTC_SEQ_RECOVERY_EN
                    state_nxt = RECOVER;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef RTC_SEQ_RECOVERY_EN
            RECOVER: begin
                if (ph_last) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign salient   = drv_en ? drv_data : 8'hzz;

    assign bus.CS    = cs;
    assign bus.WR    = wr;
    assign bus.RD    = rd;
    assign bus.AD    = ad;
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed bench for rtc_bus_sequencer. One instance at
// T_PH=4 with a read-data bus model, one at T_PH=1. The salient nets are pulled
// high so an undriven bus reads 0xFF; test bytes avoid 0xFF.
module tb_rtc_bus_sequencer;

`ifdef RTC_SEQ_RECOVERY_EN
    localparam int REC = 4;
`else
    localparam int REC = 0;
`endif

    logic clk;
    logic reset;

    rtc_bus_sequencer_if bif4 ();
    rtc_bus_sequencer_if bif1 ();
    tri1 [7:0] salient4;
    tri1 [7:0] salient1;

    logic [7:0] model_data;

    // RTC read model: drives the bus only while RD is asserted.
    assign salient4 = (bif4.RD == 1'b0) ? model_data : 8'hzz;

    rtc_bus_sequencer #(.T_PH(4)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bif4.slave),
        .salient (salient4)
    );

    rtc_bus_sequencer #(.T_PH(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bif1.slave),
        .salient (salient1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counters filled by watch()
    int cs_low, addr_ok, wdat_ok, zdat, rdat_ok, wr_lo_a, wr_lo_d, rd_lo;
    int both_low, hi_driven, done_cycle, done_count, busy_at_done, busy_cnt;
    int runs, hi_cnt, gap;
    logic [7:0] rdata_at_done;

    task automatic start_txn(input logic rw, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bif4.req   = 1'b1;
        bif4.rw    = rw;
        bif4.addr  = a;
        bif4.wdata = d;
    endtask

    // Observe ncyc cycles on the T_PH=4 instance; cycle 1 is the first after accept.
    task automatic watch(input int ncyc, input bit hold, input int pulse_at);
        logic prev_cs;
        cs_low = 0; addr_ok = 0; wdat_ok = 0; zdat = 0; rdat_ok = 0;
        wr_lo_a = 0; wr_lo_d = 0; rd_lo = 0; both_low = 0; hi_driven = 0;
        done_cycle = 0; done_count = 0; busy_at_done = 0; busy_cnt = 0;
        runs = 0; hi_cnt = 0; gap = -1; rdata_at_done = 8'h00;
        prev_cs = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (bif4.CS == 1'b0) begin
                if (prev_cs) begin
                    runs++;
                    if (runs == 2) gap = hi_cnt;
                end
                cs_low++;
                if (bif4.AD == 1'b0 && salient4 == bif4.addr) addr_ok++;
                if (bif4.AD == 1'b1 && salient4 == bif4.wdata) wdat_ok++;
                if (bif4.AD == 1'b1 && bif4.RD == 1'b1 && salient4 == 8'hFF) zdat++;
                if (bif4.RD == 1'b0 && salient4 == model_data) rdat_ok++;
            end else begin
                if (runs == 1) hi_cnt++;
                if (salient4 != 8'hFF) hi_driven++;
            end
            prev_cs = bif4.CS;
            if (bif4.WR == 1'b0 && bif4.AD == 1'b0) wr_lo_a++;
            if (bif4.WR == 1'b0 && bif4.AD == 1'b1) wr_lo_d++;
            if (bif4.RD == 1'b0) rd_lo++;
            if (bif4.WR == 1'b0 && bif4.RD == 1'b0) both_low++;
            if (bif4.busy) busy_cnt++;
            if (bif4.done) begin
                done_count++;
                if (done_cycle == 0) begin
                    done_cycle    = n;
                    busy_at_done  = int'(bif4.busy);
                    rdata_at_done = bif4.rdata;
                end
            end
            if (!hold && n == 1) bif4.req = 1'b0;
            if (hold && runs == 2) bif4.req = 1'b0;
            if (pulse_at != 0 && n == pulse_at) bif4.req = 1'b1;
            if (pulse_at != 0 && n == pulse_at + 1) bif4.req = 1'b0;
        end
    endtask

    int c1_cs, c1_wr, c1_rd, c1_addr, c1_data, c1_done;

    initial begin
        checks = 0;
        errors = 0;
        model_data = 8'h12;
        bif4.req = 1'b0; bif4.rw = 1'b0; bif4.addr = 8'h00; bif4.wdata = 8'h00;
        bif1.req = 1'b0; bif1.rw = 1'b0; bif1.addr = 8'h00; bif1.wdata = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_cs", bif4.CS, 1'b1);
        check_eq("rst_wr", bif4.WR, 1'b1);
        check_eq("rst_rd", bif4.RD, 1'b1);
        check_eq("rst_ad", bif4.AD, 1'b1);
        check_eq("rst_busy", bif4.busy, 1'b0);
        check_eq("rst_done", bif4.done, 1'b0);
        check_eq("rst_rdata", bif4.rdata, 8'h00);
        check_eq("rst_salient", salient4, 8'hFF);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Write 0x45 to 0x21
        start_txn(1'b0, 8'h21, 8'h45);
        watch(40, 1'b0, 0);
        check_eq("wr_cs_low", cs_low, 24);
        check_eq("wr_addr_cycles", addr_ok, 12);
        check_eq("wr_data_cycles", wdat_ok, 12);
        check_eq("wr_wr_lo_addr", wr_lo_a, 4);
        check_eq("wr_wr_lo_data", wr_lo_d, 4);
        check_eq("wr_rd_lo", rd_lo, 0);
        check_eq("wr_done_cycle", done_cycle, 25);
        check_eq("wr_done_count", done_count, 1);
        check_eq("wr_busy_at_done", busy_at_done, (REC != 0) ? 1 : 0);
        check_eq("wr_idle_driven", hi_driven, 0);

        // Second write pattern
        start_txn(1'b0, 8'h7E, 8'hA5);
        watch(40, 1'b0, 0);
        check_eq("wr2_data_cycles", wdat_ok, 12);
        check_eq("wr2_addr_cycles", addr_ok, 12);
        check_eq("wr2_done_cycle", done_cycle, 25);

        // Read from 0x33, RTC returns 0x12
        model_data = 8'h12;
        start_txn(1'b1, 8'h33, 8'h00);
        watch(40, 1'b0, 0);
        check_eq("rd_cs_low", cs_low, 24);
        check_eq("rd_addr_cycles", addr_ok, 12);
        check_eq("rd_z_data", zdat, 8);
        check_eq("rd_model_data", rdat_ok, 4);
        check_eq("rd_wr_lo_addr", wr_lo_a, 4);
        check_eq("rd_wr_lo_data", wr_lo_d, 0);
        check_eq("rd_rd_lo", rd_lo, 4);
        check_eq("rd_both_low", both_low, 0);
        check_eq("rd_done_cycle", done_cycle, 25);
        check_eq("rd_rdata", rdata_at_done, 8'h12);
        check_eq("rd_rdata_hold", bif4.rdata, 8'h12);

        // Request pulsed in the 5th busy cycle is dropped
        start_txn(1'b0, 8'h10, 8'h5A);
        watch(70, 1'b0, 5);
        check_eq("busyreq_cs_low", cs_low, 24);
        check_eq("busyreq_runs", runs, 1);
        check_eq("busyreq_busy_cycles", busy_cnt, 24 + REC);
        check_eq("busyreq_done_count", done_count, 1);

        // Reset during D_STB of a write
        start_txn(1'b0, 8'h44, 8'h66);
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (n == 1) bif4.req = 1'b0;
        end
        check_eq("mid_pre_wr", bif4.WR, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("mid_cs", bif4.CS, 1'b1);
        check_eq("mid_wr", bif4.WR, 1'b1);
        check_eq("mid_ad", bif4.AD, 1'b1);
        check_eq("mid_busy", bif4.busy, 1'b0);
        check_eq("mid_salient", salient4, 8'hFF);
        check_eq("mid_rdata", bif4.rdata, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        watch(30, 1'b0, 0);
        check_eq("mid_no_done", done_count, 0);
        check_eq("mid_no_cs", cs_low, 0);

        // Normal read after the reset
        model_data = 8'h3B;
        start_txn(1'b1, 8'h5C, 8'h00);
        watch(40, 1'b0, 0);
        check_eq("post_rd_done_cycle", done_cycle, 25);
        check_eq("post_rd_rdata", rdata_at_done, 8'h3B);

        // Back-to-back with req held high
        start_txn(1'b0, 8'h01, 8'h02);
        watch(80, 1'b1, 0);
        check_eq("b2b_runs", runs, 2);
`ifdef RTC_SEQ_RECOVERY_EN
        check_eq("b2b_gap_ge4", (gap >= 4) ? 1 : 0, 1);
`else
        check_eq("b2b_gap", gap, 1);
`endif
        check_eq("b2b_done_count", done_count, 2);

        // T_PH = 1 write
        @(negedge clk);
        bif1.req = 1'b1; bif1.rw = 1'b0; bif1.addr = 8'h0F; bif1.wdata = 8'h90;
        c1_cs = 0; c1_wr = 0; c1_rd = 0; c1_addr = 0; c1_data = 0; c1_done = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) bif1.req = 1'b0;
            if (bif1.CS == 1'b0) c1_cs++;
            if (bif1.WR == 1'b0) c1_wr++;
            if (bif1.RD == 1'b0) c1_rd++;
            if (bif1.CS == 1'b0 && bif1.AD == 1'b0 && salient1 == 8'h0F) c1_addr++;
            if (bif1.CS == 1'b0 && bif1.AD == 1'b1 && salient1 == 8'h90) c1_data++;
            if (bif1.done && c1_done == 0) c1_done = n;
        end
        check_eq("t1_cs_low", c1_cs, 6);
        check_eq("t1_wr_low", c1_wr, 2);
        check_eq("t1_rd_low", c1_rd, 0);
        check_eq("t1_addr_cycles", c1_addr, 3);
        check_eq("t1_data_cycles", c1_data, 3);
        check_eq("t1_done_cycle", c1_done, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequences single-byte read/write transactions from the PicoBlaze I/O port onto the real-time-clock chip's multiplexed address/data bus (`AD`, `CS`, `WR`, `RD`, `salient`). It accepts one request at a time, generates the address phase and then the data phase with programmable phase lengths, and returns read data with a one-cycle completion pulse. It sits between the processor port decode and the top-level RTC pins.

## Interface
- `T_PH`, 4: clock cycles per bus phase; legal range 1..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `rw`  in  1  1 = read, 0 = write; latched on accept.
- `addr`  in  8  RTC register address; latched on accept.
- `wdata`  in  8  write data; latched on accept.
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle pulse at transaction end.
- `rdata`  out  8  last read byte; holds its value until the next read completes.
- `AD`  out  1  0 = address phase, 1 = data phase.
- `CS`  out  1  active-low chip select.
- `WR`  out  1  active-low write strobe.
- `RD`  out  1  active-low read strobe.
- `salient`  inout  8  multiplexed bus; high-Z when not driven.

## Operation
- States: IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, plus RECOVER when `RTC_SEQ_RECOVERY_EN` is defined.
- Each non-IDLE state lasts exactly `T_PH` cycles, timed by a 4-bit phase counter that reloads on every state change.
- IDLE: `CS`, `WR`, `RD` and `AD` are 1, `salient` is Z and `busy` is 0. When `req` is 1, the block latches `rw`, `addr` and `wdata`, then moves to A_SET.
- A_SET: `CS`=0, `AD`=0, `salient` driven with `addr`.
- A_STB: adds `WR`=0.
- A_HLD: `WR`=1; `addr` remains driven.
- D_SET: `AD`=1. On a write, `salient` is driven with `wdata`. On a read, `salient` is Z.
- D_STB: a write asserts `WR`=0; a read asserts `RD`=0.
- D_HLD: the strobe returns to 1. On a write, data stays driven. On a read, `salient` was sampled into `rdata` on the last cycle of D_STB.
- Exit from D_HLD: `CS`=1, `AD`=1, `salient` goes to Z and `done` pulses for one cycle. Without recovery, the block then enters IDLE.
- `req` asserted while `busy`=1 is ignored and is not queued. The requester must present the request again after `done`.
- `req` held high continuously starts a new transaction on the first IDLE cycle.
- `WR` and `RD` are never both 0.
- `salient` is driven only while `CS`=0, except during a read data phase, when it is Z.

## Timing
- Reset values: `CS`=`WR`=`RD`=`AD`=1, `salient`=Z, `busy`=0, `done`=0, `rdata`=0x00, state IDLE.
- Reset is asynchronous. Asserting it mid-transaction forces the reset values immediately, with no bus completion and no `done`.
- Accept: `req`=1 at rising edge k in IDLE means that after edge k, `busy`=1 and the block is in A_SET.
- `CS` is low for exactly 6·`T_PH` cycles.
- The `WR`/`RD` strobe in the data phase is low for exactly `T_PH` cycles. The address-phase `WR` strobe is also low for `T_PH` cycles.
- `done`=1 in the cycle following edge k+6·`T_PH`. `rdata` is valid from that same cycle.
- Without recovery, `busy` falls in the same cycle that `done` rises, so the earliest next accept is that cycle's edge.
- With `T_PH`=1, the full transaction is 6 cycles; there are no degenerate zero-length phases.

## Configuration
- `RTC_SEQ_RECOVERY_EN` defined:
  - After D_HLD, the block enters RECOVER for `T_PH` cycles with `CS`=1 and `salient`=Z.
  - `done` pulses on the first RECOVER cycle, and `busy` stays 1 through RECOVER.
  - Back-to-back transactions therefore have at least `T_PH` cycles of `CS` high between them.
- `RTC_SEQ_RECOVERY_EN` undefined: no RECOVER state; behaviour as in Timing.

## Test plan
- **Write, `T_PH`=4.**
  - Stimulus: `req`, `rw`=0, `addr`=0x21, `wdata`=0x45.
  - Response: `salient`=0x21 with `AD`=0 for 12 cycles, then 0x45 with `AD`=1 for 12 cycles. `WR` is low for 4 cycles in each phase, `RD` stays 1, and `done` pulses at cycle 25.
- **Read, `T_PH`=4.**
  - Stimulus: `rw`=1, `addr`=0x33; the bus model drives 0x12 while `RD`=0.
  - Response: `salient` is Z during the data phase, `rdata`=0x12 when `done` pulses, and `WR` stays 1 in the data phase.
- **Request while busy.**
  - Stimulus: `req` pulsed in the 5th busy cycle.
  - Response: no second transaction occurs, and `CS` rises after 24 cycles.
- **Reset mid-transaction.**
  - Stimulus: `reset` asserted during D_STB.
  - Response: outputs take their reset values within the same cycle, no `done` is produced, and the next request runs normally.
- **Back-to-back, `req` held high.**
  - Without the macro: `CS` goes high for 1 cycle between transactions.
  - With `RTC_SEQ_RECOVERY_EN`: `CS` stays high for 4 or more cycles between transactions.
- **`T_PH`=1.**
  - Stimulus: a write.
  - Response: `CS` is low for exactly 6 cycles, and each strobe is low for 1 cycle.
